// File: rtl/mips_dmem_pkg.sv
// Shared constants and the access-type enum for the mips data-memory subsystem.
package mips_dmem_pkg;

  localparam int          DATA_W         = 32;
  localparam logic [31:0] OFF_TXDATA     = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS     = 32'h0000_0004;
  localparam logic [31:0] OFF_ERRCLR     = 32'h0000_0008;
  localparam int          STAT_FULL_BIT  = 8;
  localparam int          STAT_EMPTY_BIT = 9;
  localparam logic [31:0] UNMAPPED_RD    = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ACC_RAM,
    ACC_TXDATA,
    ACC_STATUS,
    ACC_ERRCLR,
    ACC_UNMAPPED
  } acc_e;

endpackage

// File: rtl/mips_dbg_fifo.sv
// Synchronous debug-output FIFO; count held separately so full/empty never alias.
module mips_dbg_fifo
  import mips_dmem_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W_P-1:0] wdata_i,
  output logic [DATA_W_P-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W_P-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                do_push;
  logic                do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~rst) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mips_dmem_ctrl.sv
// Data-memory subsystem: word RAM, memory-mapped debug FIFO and write-fault monitor.
module mips_dmem_ctrl
  import mips_dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter logic [31:0] IO_BASE    = 32'h0000_0400,
  parameter int          FIFO_DEPTH = 4,
  parameter int          ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             Z_R,
  input  logic             DM_WE,
  input  logic [31:0]      DM_ADDR,
  input  logic [31:0]      DM_WR_DATA,
  output logic [31:0]      DM_RD_DATA,
  output logic             DBG_VALID,
  output logic [31:0]      DBG_DATA,
  input  logic             DBG_READY,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [31:0]      ERR_ADDR
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]      ram_q [RAM_WORDS];
  logic [AW-1:0]    ram_idx;
  logic [31:0]      word_addr;
  acc_e             acc;
  logic             misaligned;

  logic [31:0]      rd_data_q, rd_data_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic [31:0]      fifo_head;
  logic [31:0]      status_w;

  logic             wr_ok;
  logic             fault;
  logic             err_clr;
  logic             ram_we;

  assign ram_idx    = DM_ADDR[AW+1:2];
  assign word_addr  = {DM_ADDR[31:2], 2'b00};
  assign misaligned = (DM_ADDR[1:0] != 2'b00);

  always_comb begin
    acc = ACC_UNMAPPED;
    if (DM_ADDR < RAM_BYTES)                    acc = ACC_RAM;
    else if (word_addr == IO_BASE + OFF_TXDATA) acc = ACC_TXDATA;
    else if (word_addr == IO_BASE + OFF_STATUS) acc = ACC_STATUS;
    else if (word_addr == IO_BASE + OFF_ERRCLR) acc = ACC_ERRCLR;
  end

  always_comb begin
    status_w                 = '0;
    status_w[CNT_W-1:0]      = fifo_cnt;
    status_w[STAT_FULL_BIT]  = fifo_full;
    status_w[STAT_EMPTY_BIT] = fifo_empty;
  end

  // Write qualification: a reset cycle swallows the access entirely.
  assign fifo_pop = DBG_VALID & DBG_READY & ~Z_R;
  assign wr_ok    = DM_WE & ~Z_R & ~misaligned;

  always_comb begin
    fault = 1'b0;
    if (DM_WE & ~Z_R) begin
      if (misaligned)                  fault = 1'b1;
      else if (acc == ACC_UNMAPPED)    fault = 1'b1;
      else if (acc == ACC_STATUS)      fault = 1'b1;
      else if (acc == ACC_TXDATA)      fault = fifo_full & ~fifo_pop;
    end
  end

  assign ram_we    = wr_ok & (acc == ACC_RAM);
  assign fifo_push = wr_ok & (acc == ACC_TXDATA) & ~fault;
  assign err_clr   = wr_ok & (acc == ACC_ERRCLR);

  always_comb begin
    rd_data_d = rd_data_q;
    if (!DM_WE) begin
      case (acc)
        ACC_RAM:    rd_data_d = ram_q[ram_idx];
        ACC_TXDATA: rd_data_d = '0;
        ACC_STATUS: rd_data_d = status_w;
        ACC_ERRCLR: rd_data_d = 32'(err_cnt_q);
        default:    rd_data_d = UNMAPPED_RD;
      endcase
    end
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (fault) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
      err_addr_d = DM_ADDR;
    end else if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Z_R) begin
      rd_data_q  <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) ram_q[ram_idx] <= DM_WR_DATA;
  end

  mips_dbg_fifo #(
    .DATA_W_P (32),
    .DEPTH    (FIFO_DEPTH),
    .CNT_W    (CNT_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (Z_R),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (DM_WR_DATA),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign DBG_VALID  = ~fifo_empty;
  assign DBG_DATA   = fifo_head;
  assign DM_RD_DATA = rd_data_q;
  assign ERR_CNT    = err_cnt_q;
  assign ERR_ADDR   = err_addr_q;

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Directed bench for mips_dmem_ctrl with hand-computed expectations.
module tb_mips_dmem_ctrl;

  logic        CLK = 1'b0;
  logic        Z_R = 1'b1;
  logic        DM_WE = 1'b0;
  logic [31:0] DM_ADDR = '0;
  logic [31:0] DM_WR_DATA = '0;
  logic [31:0] DM_RD_DATA;
  logic        DBG_VALID;
  logic [31:0] DBG_DATA;
  logic        DBG_READY = 1'b0;
  logic [7:0]  ERR_CNT;
  logic [31:0] ERR_ADDR;

  int n_tests = 0;
  int n_fail  = 0;

  mips_dmem_ctrl dut (
    .CLK        (CLK),
    .Z_R        (Z_R),
    .DM_WE      (DM_WE),
    .DM_ADDR    (DM_ADDR),
    .DM_WR_DATA (DM_WR_DATA),
    .DM_RD_DATA (DM_RD_DATA),
    .DBG_VALID  (DBG_VALID),
    .DBG_DATA   (DBG_DATA),
    .DBG_READY  (DBG_READY),
    .ERR_CNT    (ERR_CNT),
    .ERR_ADDR   (ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    DM_WE = 1'b1; DM_ADDR = a; DM_WR_DATA = d;
    tick();
    DM_WE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    DM_WE = 1'b0; DM_ADDR = a;
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    Z_R = 1'b0;
    chk("rst_rd",    DM_RD_DATA, 32'h0);
    chk("rst_valid", 32'(DBG_VALID), 32'h0);
    chk("rst_data",  DBG_DATA, 32'h0);
    chk("rst_ecnt",  32'(ERR_CNT), 32'h0);
    chk("rst_eaddr", ERR_ADDR, 32'h0);

    // RAM write/read
    wr(32'h010, 32'hDEAD_BEEF);
    chk("wr_hold_rd", DM_RD_DATA, 32'h0);
    rd(32'h010);
    chk("ram_rd", DM_RD_DATA, 32'hDEAD_BEEF);
    rd(32'h013);
    chk("ram_rd_lowbits", DM_RD_DATA, 32'hDEAD_BEEF);
    rd(32'h3FC);
    chk("ram_top_nofault", 32'(ERR_CNT), 32'h0);

    // Unmapped and misaligned
    rd(32'h500);
    chk("unmapped_rd", DM_RD_DATA, 32'hFFFF_FFFF);
    wr(32'h500, 32'h1);
    chk("unmapped_wr_cnt",  32'(ERR_CNT), 32'h1);
    chk("unmapped_wr_addr", ERR_ADDR, 32'h500);
    chk("wr_hold_rd2", DM_RD_DATA, 32'hFFFF_FFFF);
    wr(32'h012, 32'h1234_5678);
    chk("misal_cnt",  32'(ERR_CNT), 32'h2);
    chk("misal_addr", ERR_ADDR, 32'h012);
    rd(32'h010);
    chk("misal_ram_intact", DM_RD_DATA, 32'hDEAD_BEEF);
    wr(32'h408, 32'h0);
    chk("clr1", 32'(ERR_CNT), 32'h0);

    // Overfill the FIFO with the consumer stalled
    for (int i = 1; i <= 5; i++) wr(32'h400, 32'(i));
    rd(32'h404);
    chk("status_full", DM_RD_DATA, 32'h104);
    chk("ovf_cnt",  32'(ERR_CNT), 32'h1);
    chk("ovf_addr", ERR_ADDR, 32'h400);
    rd(32'h400);
    chk("txdata_rd", DM_RD_DATA, 32'h0);
    tick();
    chk("stall_hold", DBG_DATA, 32'h1);
    DBG_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(DBG_VALID), 32'h1);
      chk("drain_data",  DBG_DATA, 32'(i));
      tick();
    end
    chk("drained_valid", 32'(DBG_VALID), 32'h0);
    chk("drained_data",  DBG_DATA, 32'h0);
    DBG_READY = 1'b0;
    rd(32'h404);
    chk("status_empty", DM_RD_DATA, 32'h200);

    // Push into a full FIFO while the head is popped
    wr(32'h408, 32'h0);
    for (int i = 5; i <= 8; i++) wr(32'h400, 32'(i));
    DBG_READY = 1'b1;
    wr(32'h400, 32'h9);
    DBG_READY = 1'b0;
    chk("pp_cnt", 32'(ERR_CNT), 32'h0);
    rd(32'h404);
    chk("pp_status", DM_RD_DATA, 32'h104);
    DBG_READY = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      chk("pp_data", DBG_DATA, 32'(i));
      tick();
    end
    chk("pp_empty", 32'(DBG_VALID), 32'h0);
    DBG_READY = 1'b0;

    // Error counter saturation, STATUS write fault, clear and readback
    for (int i = 0; i < 260; i++) wr(32'h500, 32'h0);
    chk("sat_cnt", 32'(ERR_CNT), 32'hFF);
    wr(32'h404, 32'h0);
    chk("sat_hold", 32'(ERR_CNT), 32'hFF);
    chk("status_wr_addr", ERR_ADDR, 32'h404);
    wr(32'h408, 32'hFFFF_FFFF);
    chk("clr_cnt", 32'(ERR_CNT), 32'h0);
    rd(32'h408);
    chk("errclr_rd0", DM_RD_DATA, 32'h0);
    wr(32'h409, 32'h0);
    chk("misal_io_cnt",  32'(ERR_CNT), 32'h1);
    chk("misal_io_addr", ERR_ADDR, 32'h409);
    rd(32'h408);
    chk("errclr_rd1", DM_RD_DATA, 32'h1);

    // Reset mid-drain; RAM survives, write during reset is discarded
    wr(32'h020, 32'hCAFE_F00D);
    wr(32'h400, 32'hA1);
    wr(32'h400, 32'hA2);
    rd(32'h010);
    DBG_READY = 1'b1;
    tick();
    chk("mid_head", DBG_DATA, 32'hA2);
    Z_R = 1'b1;
    DM_WE = 1'b1; DM_ADDR = 32'h020; DM_WR_DATA = 32'h0;
    tick();
    DM_WE = 1'b0;
    Z_R = 1'b0;
    DBG_READY = 1'b0;
    chk("mid_rst_valid", 32'(DBG_VALID), 32'h0);
    chk("mid_rst_rd",    DM_RD_DATA, 32'h0);
    chk("mid_rst_ecnt",  32'(ERR_CNT), 32'h0);
    chk("mid_rst_eaddr", ERR_ADDR, 32'h0);
    rd(32'h020);
    chk("ram_keep_20", DM_RD_DATA, 32'hCAFE_F00D);
    rd(32'h010);
    chk("ram_keep_10", DM_RD_DATA, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_dmem_ctrl.md
Name: mips_dmem_ctrl

Overview:
- Data-memory subsystem sitting directly downstream of the mips core's data-memory port.
- Consumes DM_WE/DM_ADDR/DM_WR_DATA and returns DM_RD_DATA.
- Contains a word-organised RAM, a memory-mapped debug-output FIFO with valid/ready drain port, and an access-error monitor.
- Replaces the behavioural data memory used in simulation with synthesizable RTL.

Parameters:
- RAM_WORDS, 256, number of 32-bit RAM words (power of two); RAM occupies byte addresses 0 .. RAM_WORDS*4-1.
- IO_BASE, 32'h0000_0400, byte base of IO registers; must be above the RAM range.
- FIFO_DEPTH, 4, debug FIFO entries (power of two, >=2).
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- Z_R  in  1  reset; synchronous, active-high.
- DM_WE  in  1  write enable for the current access.
- DM_ADDR  in  32  byte address.
- DM_WR_DATA  in  32  write data.
- DM_RD_DATA  out  32  registered read data.
- DBG_VALID  out  1  FIFO head valid (FIFO not empty).
- DBG_DATA  out  32  FIFO head word; 0 when empty.
- DBG_READY  in  1  consumer accepts head when DBG_VALID=1.
- ERR_CNT  out  ERR_W  saturating count of faulted accesses.
- ERR_ADDR  out  32  DM_ADDR of the most recent faulted access.

Behaviour:
- Reset (Z_R=1 at edge): DM_RD_DATA=0; FIFO emptied (DBG_VALID=0, DBG_DATA=0); ERR_CNT=0; ERR_ADDR=0. RAM contents are not reset. Any access or pop in a reset cycle is discarded.
- Address map (decode on DM_ADDR):
  - RAM: addr < RAM_WORDS*4; word index = addr[log2(RAM_WORDS)+1:2].
  - IO_BASE+0 TXDATA: write pushes into FIFO; read returns 0.
  - IO_BASE+4 STATUS (read-only): bits[7:0] = FIFO count, bit8 = full, bit9 = empty, rest 0.
  - IO_BASE+8 ERRCLR: read returns ERR_CNT zero-extended; a write of any data clears ERR_CNT.
  - Anything else is unmapped.
- Reads (DM_WE=0): DM_RD_DATA is updated at the rising edge from the address presented in that cycle. Latency is one edge, with no stall. Unmapped reads return 32'hFFFF_FFFF. DM_ADDR[1:0] is ignored on reads.
- Writes (DM_WE=1): take effect at the edge; DM_RD_DATA holds its previous value.
- Write faults: a write is dropped and counted as a fault in each of these cases:
  - misaligned (DM_ADDR[1:0]!=0), including misaligned IO writes;
  - unmapped address;
  - write to STATUS;
  - push to TXDATA while the FIFO is full, unless a pop occurs in the same cycle.
- Error monitor: each fault increments ERR_CNT, saturating at all-ones, and loads ERR_ADDR=DM_ADDR. At most one access per cycle, so a clear and a fault never coincide.
- FIFO:
  - Push at the edge when a TXDATA write is accepted.
  - Pop at the edge when DBG_VALID & DBG_READY.
  - Simultaneous push and pop: accepted in every state, including full; count is unchanged and pointers advance; when empty (no pop possible) only the push occurs.
  - Pointers wrap modulo FIFO_DEPTH; count is held separately so full and empty are unambiguous.
  - Data is presented first-in first-out; DBG_DATA is stable while DBG_VALID=1 and DBG_READY=0.
- RAM read-during-write cannot occur (single port, one access per cycle).

Decomposition:
- Package mips_dmem_pkg holds:
  - IO offsets (TXDATA=0, STATUS=4, ERRCLR=8);
  - STATUS bit positions (full=8, empty=9);
  - UNMAPPED_RD=32'hFFFF_FFFF;
  - the access-type enum (RAM, TXDATA, STATUS, ERRCLR, UNMAPPED) produced by the decoder.
- Sub-module mips_dbg_fifo: synchronous FIFO with push/pop/full/empty/count.
- Decoder, RAM and error monitor stay in mips_dmem_ctrl.

Test Plan:
- Reset then write 0xDEADBEEF to 0x010, read 0x010: DM_RD_DATA=0xDEADBEEF after one edge; read 0x3FC (in RAM range, never written) returns whatever the RAM held, with no fault.
- Read 0x500 -> DM_RD_DATA=0xFFFFFFFF; write 0x500 -> ERR_CNT=1, ERR_ADDR=0x500; write 0x012 -> ERR_CNT=2, ERR_ADDR=0x012, RAM word 4 unchanged.
- With DBG_READY=0, push 1,2,3,4,5 to 0x400: STATUS read = 0x104 (full, count 4), ERR_CNT=1, ERR_ADDR=0x400; raise DBG_READY: DBG_DATA sequence is 1,2,3,4 with no 5, then DBG_VALID=0 and STATUS=0x200.
- FIFO full, DBG_READY=1 in the same cycle as a push of 9: count stays 4, no error, and 9 emerges last.
- Drive 256+ faults: ERR_CNT saturates at 0xFF; write 0x408 -> ERR_CNT=0; read 0x408 -> DM_RD_DATA=0.
- Push 2 entries, assert Z_R for one edge mid-drain: DBG_VALID=0, DM_RD_DATA=0, ERR_CNT=0; RAM data written before reset reads back intact.
